sys_nios2_qsys_0_mul_seq: RTL and testbench

//  Two-pass sequencer upstream/downstream of the Nios II 16x32 multiplier cell (mult_cell).
//  The cell computes only src1 * src2[15:0] (low 32 bits, registered, unsigned).

---
 rtl/sys_nios2_qsys_0_mul_seq_if.sv | 15 +
 rtl/sys_nios2_qsys_0_mul_seq.sv | 61 ++++++
 tb/tb_sys_nios2_qsys_0_mul_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sys_nios2_qsys_0_mul_seq_if.sv
// sys_nios2_qsys_0_mul_seq_if: request/response handshake bundle of the two-pass multiply sequencer.
interface sys_nios2_qsys_0_mul_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    modport master (output req_valid, req_src1, req_src2, flush, rsp_ready,
                    input  req_ready, rsp_valid, rsp_result);
    modport slave  (input  req_valid, req_src1, req_src2, flush, rsp_ready,
                    output req_ready, rsp_valid, rsp_result);
endinterface

// File: rtl/sys_nios2_qsys_0_mul_seq.sv
// sys_nios2_qsys_0_mul_seq: runs two passes through the 16x32 mult cell and sums them into a 32x32 low product.
module sys_nios2_qsys_0_mul_seq #(
    parameter int CELL_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    sys_nios2_qsys_0_mul_seq_if.slave  bus,
    output logic [31:0]                mul_src1,
    output logic [31:0]                mul_src2,
    input  logic [31:0]                mul_cell_result
);
    localparam int CW = $clog2(CELL_LATENCY + 3);
    typedef enum logic [2:0] {IDLE, ISSUE1, ISSUE2, WAIT, SUM, DONE} state_t;
    state_t state, next;
    logic [CW-1:0] cnt;
    logic [31:0] a, b, acc, result;
    logic accept, abort, capture;
    assign accept = bus.req_valid && state == IDLE;
    assign abort = bus.flush && state != IDLE;
    // cnt reaches 1 exactly on the cycle pass 1's product emerges from the cell
    assign capture = state != IDLE && cnt == CW'(1) && !abort;
    assign bus.req_ready = state == IDLE;
    assign bus.rsp_valid = state == DONE;
    assign bus.rsp_result = result;
    assign mul_src1 = state == ISSUE1 ? a : state == ISSUE2 ? {a[15:0], 16'h0} : '0;
    assign mul_src2 = state == ISSUE1 ? b : state == ISSUE2 ? {16'h0, b[31:16]} : '0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:         next = accept ? ISSUE1 : IDLE;
            ISSUE1:       next = ISSUE2;
            ISSUE2, WAIT: next = cnt == CW'(1) ? SUM : WAIT;
            SUM:          next = DONE;
            DONE:         next = bus.rsp_ready ? IDLE : DONE;
            default:      next = IDLE;
        endcase
        if (abort) next = IDLE;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a <= '0;
            b <= '0;
            acc <= '0;
            cnt <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                a <= bus.req_src1;
                b <= bus.req_src2;
                cnt <= CW'(CELL_LATENCY + 1);
            end else if (abort) cnt <= '0;
            else if (cnt != '0) cnt <= cnt - CW'(1);
            if (capture) acc <= mul_cell_result;
            if (state == SUM && !abort) result <= acc + mul_cell_result;
        end
    end
endmodule

// File: tb/tb_sys_nios2_qsys_0_mul_seq.sv
// tb_sys_nios2_qsys_0_mul_seq: checks the sequencer at cell latency 1 and 3 against plain 32-bit products.
module tb_sys_nios2_qsys_0_mul_seq;
    logic clk, reset_n, rst3_n;
    logic [31:0] m1_src1, m1_src2, c1_res;
    logic [31:0] m3_src1, m3_src2;
    logic [31:0] p3 [3];
    int total, bad;
    sys_nios2_qsys_0_mul_seq_if bus1();
    sys_nios2_qsys_0_mul_seq_if bus3();
    sys_nios2_qsys_0_mul_seq #(.CELL_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus1),
        .mul_src1(m1_src1), .mul_src2(m1_src2), .mul_cell_result(c1_res));
    sys_nios2_qsys_0_mul_seq #(.CELL_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(rst3_n), .bus(bus3),
        .mul_src1(m3_src1), .mul_src2(m3_src2), .mul_cell_result(p3[2]));
    initial clk = 0;
    always #5 clk = ~clk;
    // behavioural cells: A * B[15:0], registered, latency 1 and 3
    always @(posedge clk) begin
        c1_res <= 32'(m1_src1 * m1_src2[15:0]);
        p3[0] <= 32'(m3_src1 * m3_src2[15:0]);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          hold;
    } vec_t;
    vec_t vecs [6];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic rv(input bit sel);
        return sel ? bus3.rsp_valid : bus1.rsp_valid;
    endfunction
    function automatic logic rdy(input bit sel);
        return sel ? bus3.req_ready : bus1.req_ready;
    endfunction
    function automatic logic [31:0] rr(input bit sel);
        return sel ? bus3.rsp_result : bus1.rsp_result;
    endfunction
    function automatic logic [31:0] s1(input bit sel);
        return sel ? m3_src1 : m1_src1;
    endfunction
    function automatic logic [31:0] s2(input bit sel);
        return sel ? m3_src2 : m1_src2;
    endfunction
    task automatic set_req(input bit sel, input logic v, input logic [31:0] a, input logic [31:0] b, input logic fl);
        if (sel) begin
            bus3.req_valid = v; bus3.req_src1 = a; bus3.req_src2 = b; bus3.flush = fl;
        end else begin
            bus1.req_valid = v; bus1.req_src1 = a; bus1.req_src2 = b; bus1.flush = fl;
        end
    endtask
    task automatic set_rdy(input bit sel, input logic r);
        if (sel) bus3.rsp_ready = r;
        else bus1.rsp_ready = r;
    endtask
    task automatic run(input bit sel, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit fl, output logic [31:0] res);
        int lat;
        @(negedge clk);
        chk("req_ready before accept", 32'(rdy(sel)), 1);
        set_req(sel, 1'b1, a, b, fl);
        @(negedge clk);
        set_req(sel, 1'b0, '0, '0, 1'b0);
        chk("pass1 mul_src1", s1(sel), a);
        chk("pass1 mul_src2", s2(sel), b);
        @(negedge clk);
        chk("pass2 mul_src1", s1(sel), {a[15:0], 16'h0});
        chk("pass2 mul_src2", s2(sel), {16'h0, b[31:16]});
        lat = 2;
        while (!rv(sel) && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp latency", 32'(lat), sel ? 32'd6 : 32'd4);
        res = rr(sel);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("held rsp_valid", 32'(rv(sel)), 1);
            chk("held rsp_result", rr(sel), res);
            chk("held req_ready", 32'(rdy(sel)), 0);
        end
        set_rdy(sel, 1'b1);
        @(negedge clk);
        set_rdy(sel, 1'b0);
        chk("rsp_valid after handshake", 32'(rv(sel)), 0);
        chk("req_ready after handshake", 32'(rdy(sel)), 1);
    endtask
    initial begin
        logic [31:0] res, a, b;
        bit sel;
        total = 0;
        bad = 0;
        vecs[0] = '{32'd3, 32'd5, 32'h0000000F, 0};
        vecs[1] = '{32'h00010001, 32'h00010001, 32'h00020001, 1};
        vecs[2] = '{32'd3, 32'h00010000, 32'h00030000, 0};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 2};
        vecs[4] = '{32'h00010000, 32'h00010000, 32'h00000000, 0};
        vecs[5] = '{32'h00001234, 32'h00000010, 32'h00012340, 10};
        reset_n = 0;
        rst3_n = 0;
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, '0, '0, 1'b0);
        set_rdy(0, 1'b0);
        set_rdy(1, 1'b0);
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("reset req_ready", 32'(rdy(s[0])), 1);
            chk("reset rsp_valid", 32'(rv(s[0])), 0);
            chk("reset rsp_result", rr(s[0]), 0);
            chk("reset mul_src1", s1(s[0]), 0);
            chk("reset mul_src2", s2(s[0]), 0);
        end
        reset_n = 1;
        rst3_n = 1;
        for (int i = 0; i < 6; i++) begin
            run(0, vecs[i].a, vecs[i].b, vecs[i].hold, 0, res);
            chk("table result", res, vecs[i].exp);
        end
        // flush while pass 2 is in flight; its late product must not leak into the next op
        @(negedge clk);
        set_req(0, 1'b1, 32'h100, 32'h300, 1'b0);
        @(negedge clk);
        set_req(0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        bus1.flush = 1;
        @(negedge clk);
        bus1.flush = 0;
        chk("flush req_ready", 32'(bus1.req_ready), 1);
        chk("flush rsp_valid", 32'(bus1.rsp_valid), 0);
        chk("flush mul_src1", m1_src1, 0);
        chk("flush mul_src2", m1_src2, 0);
        bus1.rsp_ready = 1;
        repeat (4) begin
            @(negedge clk);
            chk("no rsp after flush", 32'(bus1.rsp_valid), 0);
        end
        bus1.rsp_ready = 0;
        run(0, 32'd7, 32'd6, 0, 0, res);
        chk("op after flush", res, 32'h0000002A);
        run(0, 32'd9, 32'h11, 0, 1, res);
        chk("flush in idle with accept", res, 32'h00000099);
        run(1, 32'h11, 32'd3, 2, 0, res);
        chk("latency3 result", res, 32'h00000033);
        // async reset of the latency-3 instance while it sits in WAIT
        @(negedge clk);
        set_req(1, 1'b1, 32'd5, 32'd5, 1'b0);
        @(negedge clk);
        set_req(1, 1'b0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        rst3_n = 0;
        #1;
        chk("mid-op reset req_ready", 32'(bus3.req_ready), 1);
        chk("mid-op reset rsp_valid", 32'(bus3.rsp_valid), 0);
        chk("mid-op reset rsp_result", bus3.rsp_result, 0);
        chk("mid-op reset mul_src1", m3_src1, 0);
        chk("mid-op reset mul_src2", m3_src2, 0);
        @(negedge clk);
        rst3_n = 1;
        bus3.rsp_ready = 1;
        repeat (6) begin
            @(negedge clk);
            chk("no rsp after reset", 32'(bus3.rsp_valid), 0);
        end
        bus3.rsp_ready = 0;
        run(1, 32'd2, 32'd2, 0, 0, res);
        chk("op after reset", res, 32'd4);
        for (int i = 0; i < 24; i++) begin
            sel = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if (i % 4 == 0) b[31:16] = '0;
            if (i % 4 == 1) a = a & 32'hFFFF0000;
            run(sel, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)), res);
            chk("random product", res, a * b);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
